// File: rtl/systolic_pkg.sv
// Shared types, default sizing and the saturating adder for the systolic engine.
// Latency: n/a (declarations and a combinational helper function only).
// Backpressure: n/a.
package systolic_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  localparam int N_DEF     = 4;
  localparam int DW_DEF    = 16;
  localparam int ACC_W_DEF = 32;
  localparam int K_MAX_DEF = 256;

  // Working width of the saturating adder; wide enough that an ACC_W-bit
  // accumulator plus a 2*DW-bit product cannot overflow it (ACC_W <= 62).
  localparam int SAT_W = 64;

  typedef logic signed [DW_DEF-1:0]    opnd_t;
  typedef logic signed [ACC_W_DEF-1:0] acc_t;
  typedef logic signed [SAT_W-1:0]     sat_t;

  // Adds two sign-extended values and clamps the sum into the signed range of
  // a w-bit accumulator; clamped reports whether the clamp engaged.
  function automatic sat_t sat_add(input sat_t a, input sat_t b,
                                   input int unsigned w, output logic clamped);
    sat_t s, hi, lo;
    s  = a + b;
    hi = (sat_t'(1) <<< (w - 1)) - sat_t'(1);
    lo = -hi - sat_t'(1);
    clamped = 1'b0;
    if (s > hi) begin
      s = hi;
      clamped = 1'b1;
    end else if (s < lo) begin
      s = lo;
      clamped = 1'b1;
    end
    return s;
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// Processing element: registers a eastward and w southward, accumulates a*w.
// Latency: operands leave one cycle after arrival; product lands in acc one cycle later.
// Backpressure: none; zeros are fed in when no data flows. SYSTOLIC_SATURATE_EN enables clamping.
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,     // zero accumulator and ovf
  input  logic signed [DW-1:0]    a_west,
  input  logic signed [DW-1:0]    w_north,
  output logic signed [DW-1:0]    a_east,  // registered a, also the multiplier operand
  output logic signed [DW-1:0]    w_south, // registered w, also the multiplier operand
  output logic signed [ACC_W-1:0] acc,
  output logic                    ovf      // sticky clamp indication
);

  logic signed [2*DW-1:0]  prod;
  logic signed [ACC_W-1:0] prod_x;
  logic signed [ACC_W-1:0] acc_nxt;
  logic                    ovf_hit;

  assign prod   = a_east * w_south;
  assign prod_x = ACC_W'(prod);  // sign-extending cast

`ifdef SYSTOLIC_SATURATE_EN
  always_comb begin
    sat_t s;
    ovf_hit = 1'b0;
    s       = sat_add(SAT_W'(acc), SAT_W'(prod_x), ACC_W, ovf_hit);
    acc_nxt = ACC_W'(s);
  end
`else
  assign acc_nxt = acc + prod_x;  // wraps modulo 2^ACC_W
  assign ovf_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_east  <= '0;
      w_south <= '0;
      acc     <= '0;
      ovf     <= 1'b0;
    end else begin
      a_east  <= a_west;
      w_south <= w_north;
      if (clr) begin
        acc <= '0;
        ovf <= 1'b0;
      end else begin
        acc <= acc_nxt;
        ovf <= ovf | ovf_hit;
      end
    end
  end

endmodule

// File: rtl/systolic_mm_engine.sv
// N x N output-stationary systolic C = A*W over inner dimension k_len (SYSTOLIC_SATURATE_EN clamps).
// Latency: out_valid rises 2N cycles after the edge accepting the last beat.
// Backpressure: in_ready only in LOAD (bubbles allowed); result held in DONE until out_ready.
module systolic_mm_engine
  import systolic_pkg::*;
#(
  parameter  int N     = N_DEF,
  parameter  int DW    = DW_DEF,
  parameter  int ACC_W = ACC_W_DEF,
  parameter  int K_MAX = K_MAX_DEF,
  localparam int KW    = $clog2(K_MAX + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [KW-1:0]        k_len,
  input  logic [N*DW-1:0]      a_in,
  input  logic [N*DW-1:0]      w_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [N*N*ACC_W-1:0] c_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 ovf
);

  localparam int DCW = $clog2(2 * N);

  state_t         state, state_nxt;
  logic [KW-1:0]  k_lat, beat_cnt, k_clamp;
  logic [DCW-1:0] drn_cnt;
  logic           clr, beat_acc, last_beat;

  assign k_clamp   = (k_len > KW'(K_MAX)) ? KW'(K_MAX) : k_len;
  assign beat_acc  = (state == LOAD) && in_valid;
  assign last_beat = beat_acc && (beat_cnt == k_lat - KW'(1));
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    clr       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          clr       = 1'b1;
          state_nxt = (k_len == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        if (last_beat) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (drn_cnt == '0) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_lat    <= '0;
      beat_cnt <= '0;
      drn_cnt  <= '0;
    end else begin
      if (state == IDLE && start) begin
        k_lat    <= k_clamp;
        beat_cnt <= '0;
      end
      if (beat_acc) beat_cnt <= beat_cnt + KW'(1);
      // 2N-1 drain cycles after the last beat let it reach PE(N-1,N-1).
      if (last_beat) drn_cnt <= DCW'(2 * N - 1);
      else if (state == DRAIN && drn_cnt != '0) drn_cnt <= drn_cnt - DCW'(1);
    end
  end

  // Everything outside an accepted beat enters the array as zeros, so the
  // accumulators hold steady in DRAIN tail, DONE and IDLE.
  logic [N*DW-1:0]           a_g, w_g;
  logic [N-1:0][DW-1:0]      a_edge, w_edge;
  assign a_g = beat_acc ? a_in : '0;
  assign w_g = beat_acc ? w_in : '0;

  for (genvar i = 0; i < N; i++) begin : g_skew
    if (i == 0) begin : g_direct
      assign a_edge[i] = a_g[i*DW +: DW];
      assign w_edge[i] = w_g[i*DW +: DW];
    end else begin : g_dly
      logic [DW-1:0] a_sr [i];
      logic [DW-1:0] w_sr [i];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < i; k++) begin
            a_sr[k] <= '0;
            w_sr[k] <= '0;
          end
        end else begin
          a_sr[0] <= a_g[i*DW +: DW];
          w_sr[0] <= w_g[i*DW +: DW];
          for (int k = 1; k < i; k++) begin
            a_sr[k] <= a_sr[k-1];
            w_sr[k] <= w_sr[k-1];
          end
        end
      end
      assign a_edge[i] = a_sr[i-1];
      assign w_edge[i] = w_sr[i-1];
    end
  end

  logic signed [DW-1:0] a_h [N][N];
  logic signed [DW-1:0] w_v [N][N];
  logic [N*N-1:0]       pe_ovf;

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic signed [DW-1:0] a_src, w_src;
      if (j == 0) begin : g_a0
        assign a_src = a_edge[i];
      end else begin : g_an
        assign a_src = a_h[i][j-1];
      end
      if (i == 0) begin : g_w0
        assign w_src = w_edge[j];
      end else begin : g_wn
        assign w_src = w_v[i-1][j];
      end
      systolic_pe #(.DW(DW), .ACC_W(ACC_W)) u_pe (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .a_west  (a_src),
        .w_north (w_src),
        .a_east  (a_h[i][j]),
        .w_south (w_v[i][j]),
        .acc     (c_out[(i*N+j)*ACC_W +: ACC_W]),
        .ovf     (pe_ovf[i*N+j])
      );
    end
  end

  assign ovf = |pe_ovf;

endmodule

// File: tb/tb_systolic_mm_engine.sv
module tb_systolic_mm_engine;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int AW = 32;
  localparam int KW = 9;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [KW-1:0]     k_len = '0;
  logic [N*DW-1:0]   a_in = '0;
  logic [N*DW-1:0]   w_in = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [N*N*AW-1:0] c_out;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              busy;
  logic              ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  systolic_mm_engine #(.N(N), .DW(DW), .ACC_W(AW), .K_MAX(256)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len),
    .a_in(a_in), .w_in(w_in), .in_valid(in_valid), .in_ready(in_ready),
    .c_out(c_out), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .ovf(ovf)
  );

  typedef struct {
    int k;
    int a [4][8];     // A[i][t]
    int w [8][4];     // W[t][j]
    int bub_at;       // bubble inserted after this beat index (-1 none)
    int bub_len;
    bit pre_rst;      // abort a k=8 job with reset first
    bit start_mid;    // pulse start with another k_len during LOAD
    int c [4][4];
    bit ovf_e;
  } vec_t;

  vec_t v [5];

  int a2 [4][2] = '{'{1, -1}, '{2, 0}, '{3, 1}, '{4, 2}};
  int w2 [2][4] = '{'{1, 0, 2, -3}, '{5, 6, 7, 8}};
  int c2 [4][4] = '{'{-4, -6, -5, -11}, '{2, 0, 4, -6}, '{8, 6, 13, -1}, '{14, 12, 22, 4}};

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int cel(input int i, input int j);
    return $signed(c_out[(i*N+j)*AW +: AW]);
  endfunction

  task automatic run_vec(input int idx, input vec_t x);
    int lat;
    bit rdy_bad;
    if (x.pre_rst) begin
      start = 1'b1; k_len = KW'(8);
      step();
      start = 1'b0;
      for (int t = 0; t < 3; t++) begin
        in_valid = 1'b1; a_in = {N{16'sd5}}; w_in = {N{16'sd5}};
        step();
      end
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_out_valid", out_valid, 0);
      chk("rst_mid_c_zero", (c_out == '0), 1);
      step();
      rst_n = 1'b1;
      step();
    end
    start = 1'b1; k_len = KW'(x.k);
    step();
    start = 1'b0;
    chk($sformatf("v%0d_in_ready_load", idx), in_ready, 1);
    for (int t = 0; t < x.k; t++) begin
      in_valid = 1'b1;
      for (int i = 0; i < N; i++) begin
        a_in[i*DW +: DW] = DW'(x.a[i][t]);
        w_in[i*DW +: DW] = DW'(x.w[t][i]);
      end
      if (x.start_mid && t == 1) begin
        start = 1'b1; k_len = KW'(1);
      end
      step();
      start = 1'b0;
      if (t == x.bub_at) begin
        for (int b = 0; b < x.bub_len; b++) begin
          in_valid = 1'b0; a_in = {N{16'h7abc}}; w_in = {N{16'h1357}};
          step();
        end
        chk($sformatf("v%0d_in_ready_bubble", idx), in_ready, 1);
      end
    end
    // Junk offered with in_valid high after the last beat must be ignored.
    in_valid = 1'b1; a_in = {N{16'h2222}}; w_in = {N{16'h3333}};
    lat = 0; rdy_bad = 1'b0;
    while (!out_valid && lat < 40) begin
      if (in_ready) rdy_bad = 1'b1;
      step();
      lat++;
    end
    in_valid = 1'b0;
    chk($sformatf("v%0d_latency", idx), lat, 2 * N);
    chk($sformatf("v%0d_in_ready_drain", idx), rdy_bad, 0);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        chk($sformatf("v%0d_c%0d%0d", idx, i, j), cel(i, j), x.c[i][j]);
    chk($sformatf("v%0d_ovf", idx), ovf, x.ovf_e);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk($sformatf("v%0d_idle_out_valid", idx), out_valid, 0);
    chk($sformatf("v%0d_idle_busy", idx), busy, 0);
    chk($sformatf("v%0d_idle_c_held", idx), cel(0, 0), x.c[0][0]);
  endtask

  initial begin
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        v[0].a[i][j] = (i == j) ? 1 : 0;
        v[0].w[i][j] = i * 4 + j + 1;
        v[0].c[i][j] = i * 4 + j + 1;
      end
    v[0].k = 4; v[0].bub_at = -1;

    for (int i = 0; i < 4; i++) begin
      for (int t = 0; t < 5; t++) begin
        v[1].a[i][t] = 3;
        v[1].w[t][i] = 3;
      end
      for (int j = 0; j < 4; j++) v[1].c[i][j] = 45;
    end
    v[1].k = 5; v[1].bub_at = 1; v[1].bub_len = 2;

    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        if (j < 2) v[2].a[i][j] = a2[i][j];
        if (i < 2) v[2].w[i][j] = w2[i][j];
        v[2].c[i][j] = c2[i][j];
      end
    v[2].k = 2; v[2].bub_at = -1; v[2].pre_rst = 1'b1;

    for (int i = 0; i < 4; i++)
      for (int t = 0; t < 3; t++) begin
        v[3].a[i][t] = 1;
        v[3].w[t][i] = i + 1;
      end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) v[3].c[i][j] = 3 * (j + 1);
    v[3].k = 3; v[3].bub_at = -1; v[3].start_mid = 1'b1;

    for (int t = 0; t < 3; t++) begin
      v[4].a[0][t] = -32768;
      v[4].w[t][0] = -32768;
    end
`ifdef SYSTOLIC_SATURATE_EN
    v[4].c[0][0] = 2147483647; v[4].ovf_e = 1'b1;
`else
    v[4].c[0][0] = -1073741824; v[4].ovf_e = 1'b0;
`endif
    v[4].k = 3; v[4].bub_at = -1;

    #2;
    chk("reset_busy", busy, 0);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_ovf", ovf, 0);
    chk("reset_c_zero", (c_out == '0), 1);
    step();
    rst_n = 1'b1;
    step();

    for (int n = 0; n < 5; n++) run_vec(n, v[n]);

    // k_len = 0: straight to DONE with cleared result, held under backpressure.
    start = 1'b1; k_len = '0;
    step();
    start = 1'b0;
    chk("k0_out_valid", out_valid, 1);
    chk("k0_busy", busy, 1);
    chk("k0_c_zero", (c_out == '0), 1);
    chk("k0_ovf_cleared", ovf, 0);
    for (int c = 0; c < 10; c++) begin
      step();
      chk($sformatf("k0_hold%0d_valid", c), out_valid, 1);
      chk($sformatf("k0_hold%0d_c_zero", c), (c_out == '0), 1);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("k0_idle_out_valid", out_valid, 0);
    chk("k0_idle_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
